data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Parameters
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_STATES, default 1: extra cycles inserted before each response (0..15).

Interface
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset: asynchronous assert, active-low.
REQ-005 cs  in  1  chip select, active-low; 0 means a request is present.
REQ-006 wr  in  1  0 = store, 1 = load; sampled with cs.
REQ-007 mask  in  4  byte enables for a store; bit i enables byte lane i (data_wr[8i+7:8i]).
REQ-008 addr  in  32  byte address; addr[1:0] is ignored; word index is addr[log2(DEPTH_WORDS)+1:2].
REQ-009 data_wr  in  32  store data, already lane-aligned by the initiator.
REQ-010 data_rd  out  32  load data, the full word, registered.
REQ-011 ready  out  1  one-cycle pulse marking completion of the accepted request.
REQ-012 err  out  1  valid only while ready=1; marks a request rejected with no side effect.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 In IDLE, cs=0 at a rising edge SHALL accept the request and capture wr, mask, addr and data_wr into internal registers.
REQ-015 On acceptance, the FSM SHALL go to WAIT and load the wait counter with WAIT_STATES when WAIT_STATES>0, otherwise it SHALL go directly to RESP.
REQ-016 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL go to RESP on the edge where the counter equals 1.
REQ-017 Latency SHALL be WAIT_STATES+1 cycles, counted from the accepting edge to the edge that asserts ready.
REQ-018 In RESP, ready SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE.
REQ-019 Inputs SHALL be ignored in WAIT and RESP; only captured values are used.
REQ-020 A cs=0 present at the edge leaving RESP SHALL NOT be accepted; it is accepted at the next edge in IDLE if cs is still 0.
REQ-021 A request SHALL be flagged as an error (err=1) if the word index is at or beyond DEPTH_WORDS, where address bits above the index range are nonzero.
REQ-022 A store SHALL also be flagged as an error if its mask is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111 or 0000.
REQ-023 A store with no error SHALL update only the byte lanes enabled by mask, at the same edge that asserts ready.
REQ-024 A store with mask 0000 SHALL complete normally with ready=1 and err=0, and SHALL leave memory unchanged.
REQ-025 A load with no error SHALL update data_rd, at the same edge that asserts ready, with the memory word as it stands before any store completing in that same cycle.
REQ-026 A load with an error SHALL set data_rd to 0.
REQ-027 data_rd SHALL hold its value until the next load completes; stores SHALL NOT change data_rd.
REQ-028 A store with an error SHALL leave memory unchanged.

Reset
REQ-029 While rst_n=0: state SHALL be IDLE, counter 0, ready 0, err 0, data_rd 0x00000000.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Asserting reset during WAIT or RESP SHALL abort the request; no store is committed and no ready is issued.
REQ-032 The first request after reset SHALL be accepted no earlier than the first rising edge on which rst_n=1.

Verification
REQ-033 WAIT_STATES=1: store 0xDEADBEEF with mask 1111 to 0x10, then load 0x10 -> ready two cycles after each accept; data_rd=0xDEADBEEF; err=0.
REQ-034 Store 0x0000AA00 with mask 0010 to 0x10, then load 0x10 -> data_rd=0xDEADAAEF.
REQ-035 Store with mask 0101 to 0x10 -> ready=1 and err=1; a following load of 0x10 still returns 0xDEADAAEF.
REQ-036 DEPTH_WORDS=1024: load from 0x1000 -> ready=1, err=1, data_rd=0; a store to 0x1000 leaves word 0 unchanged.
REQ-037 WAIT_STATES=0: cs held at 0 continuously, issuing loads -> one ready every two cycles (IDLE/RESP alternation) and no double-accept within RESP.
REQ-038 rst_n pulsed low during WAIT of a store -> no ready; target word unchanged; outputs 0; the next request completes normally.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a fixed-latency request/response handshake.
// Requests are captured in IDLE, optionally delayed in WAIT, and answered from RESP.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cs_i,
    input  logic        wr_i,
    input  logic [3:0]  mask_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_wr_i,
    output logic [31:0] data_rd_o,
    output logic        ready_o,
    output logic        err_o
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          wr_q;
    logic [3:0]    mask_q;
    logic [29:0]   waddr_q;
    logic [31:0]   wdata_q;
    logic          ready_q;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx_d;
    logic          range_err_d;
    logic          mask_err_d;
    logic          req_err_d;
    logic          unused_addr_lsb;

    // Byte offset within the word carries no meaning for a word-wide memory.
    assign unused_addr_lsb = ^addr_i[1:0];

    assign idx_d       = waddr_q[AW-1:0];
    assign range_err_d = |(waddr_q >> AW);
    assign mask_err_d  = !(mask_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                          4'b1000, 4'b0011, 4'b1100, 4'b1111});
    assign req_err_d   = range_err_d | (~wr_q & mask_err_d);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b1;
            mask_q  <= 4'd0;
            waddr_q <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!cs_i) begin
                        wr_q    <= wr_i;
                        mask_q  <= mask_i;
                        waddr_q <= addr_i[31:2];
                        wdata_q <= data_wr_i;
                        if (WAIT_STATES > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_STATES);
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    // Leaving RESP is the completion edge; cs is deliberately not sampled here.
                    ready_q <= 1'b1;
                    err_q   <= req_err_d;
                    if (wr_q) begin
                        rdata_q <= req_err_d ? 32'd0 : mem_q[idx_d];
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory is not reset; an aborting reset forces IDLE so no store commits.
    always_ff @(posedge clk_i) begin
        if (state_q == RESP && !wr_q && !req_err_d) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) begin
                    mem_q[idx_d][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign data_rd_o = rdata_q;
    assign ready_o   = ready_q;
    assign err_o     = err_q;

endmodule
